// File: rtl/display_pkg.sv
// Shared constants for the seven-segment display path: glyph table, FSM state
// encoding and the double-dabble add-3 correction.
package display_pkg;

  localparam logic [7:0] SEG_DIGIT [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };
  localparam logic [7:0] SEG_DASH  = 8'h40;
  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam int unsigned DEC_MAX  = 9999;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_ENCODE = 2'd2
  } state_e;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the left shift.
  function automatic logic [19:0] dd_adjust(input logic [19:0] bcd);
    logic [19:0] r;
    r = bcd;
    for (int i = 0; i < 5; i++) begin
      if (r[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = r[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = r[4*i +: 4];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble-to-glyph lookup (segments a..g, active-high).
module hex_to_seg7
  import display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_DIGIT[nibble_i][6:0];

endmodule

// File: rtl/display_value_encoder.sv
// Converts a binary value to four seven-segment glyphs (decimal via iterative
// double-dabble, or hex) and presents them as one packed word.
module display_value_encoder
  import display_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] value,
  input  logic             hex_mode,
  input  logic             blank_lz,
  input  logic [3:0]       dp,
  output logic [31:0]      four_digits,
  output logic             updated
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e          state_q;
  logic [WIDTH-1:0] bin_q;
  logic [19:0]     bcd_q;
  logic [CW-1:0]   cnt_q;
  logic            hex_q;
  logic            blank_q;
  logic            ovf_q;
  logic [3:0]      dp_q;
  logic [31:0]     four_digits_q;
  logic            updated_q;

  logic [WIDTH+19:0] shift_d;
  logic [15:0]       hex_s;
  logic [3:0]        nib_s   [4];
  logic [6:0]        glyph_s [4];
  logic [31:0]       digits_d;

  assign shift_d  = {dd_adjust(bcd_q), bin_q} << 1;
  assign in_ready = (state_q == ST_IDLE);

  // Hex mode reads the captured value directly from the (unshifted) binary register.
  if (WIDTH >= 16) begin : g_hex_wide
    assign hex_s = bin_q[15:0];
  end else begin : g_hex_narrow
    assign hex_s = {{(16 - WIDTH){1'b0}}, bin_q};
  end

  for (genvar g = 0; g < 4; g++) begin : g_digit
    assign nib_s[g] = hex_q ? hex_s[4*g +: 4] : bcd_q[4*g +: 4];
    hex_to_seg7 u_seg (
      .nibble_i (nib_s[g]),
      .seg_o    (glyph_s[g])
    );
  end

  // Per-digit dash/blank/glyph selection with the decimal point ORed on top.
  always_comb begin
    logic [7:0] byte_v;
    digits_d = 32'h0000_0000;
    byte_v   = SEG_BLANK;
    for (int i = 0; i < 4; i++) begin
      if (!hex_q && ovf_q) begin
        byte_v = SEG_DASH;
      end else if (!hex_q && blank_q && (i != 0) && ((bcd_q[15:0] >> (4*i)) == 16'h0000)) begin
        byte_v = SEG_BLANK;
      end else begin
        byte_v = {1'b0, glyph_s[i]};
      end
      digits_d[8*i +: 8] = byte_v | {dp_q[i], 7'b000_0000};
    end
  end

  // Control FSM with capture, double-dabble datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      bin_q         <= '0;
      bcd_q         <= 20'h0_0000;
      cnt_q         <= '0;
      hex_q         <= 1'b0;
      blank_q       <= 1'b0;
      ovf_q         <= 1'b0;
      dp_q          <= 4'h0;
      four_digits_q <= 32'h0000_0000;
      updated_q     <= 1'b0;
    end else begin
      updated_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            bin_q   <= value;
            bcd_q   <= 20'h0_0000;
            cnt_q   <= '0;
            hex_q   <= hex_mode;
            blank_q <= blank_lz;
            ovf_q   <= (64'(value) > 64'(DEC_MAX));
            dp_q    <= dp;
            state_q <= hex_mode ? ST_ENCODE : ST_SHIFT;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          bcd_q <= shift_d[WIDTH+19:WIDTH];
          bin_q <= shift_d[WIDTH-1:0];
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= ST_ENCODE;
          end else begin
            state_q <= ST_SHIFT;
          end
        end
        ST_ENCODE: begin
          four_digits_q <= digits_d;
          updated_q     <= 1'b1;
          state_q       <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign four_digits = four_digits_q;
  assign updated     = updated_q;

endmodule

// File: tb/tb_display_value_encoder.sv
// Directed plus randomized bench for display_value_encoder against an
// arithmetic reference model of the digit/glyph rules.
module tb_display_value_encoder;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] value;
  logic             hex_mode;
  logic             blank_lz;
  logic [3:0]       dp;
  logic [31:0]      four_digits;
  logic             updated;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  localparam logic [7:0] GLYPH [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  display_value_encoder #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .value       (value),
    .hex_mode    (hex_mode),
    .blank_lz    (blank_lz),
    .dp          (dp),
    .four_digits (four_digits),
    .updated     (updated)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(int unsigned v, bit hx, bit bl, logic [3:0] dpv);
    logic [31:0] r;
    int d [4];
    int msd;
    int unsigned p;
    r = 32'h0;
    if (hx) begin
      for (int i = 0; i < 4; i++) r[8*i +: 8] = GLYPH[(v >> (4*i)) & 15];
    end else if (v > 9999) begin
      for (int i = 0; i < 4; i++) r[8*i +: 8] = 8'h40;
    end else begin
      p = 1;
      msd = 0;
      for (int i = 0; i < 4; i++) begin
        d[i] = int'((v / p) % 10);
        p = p * 10;
        if (d[i] != 0) msd = i;
      end
      for (int i = 0; i < 4; i++) r[8*i +: 8] = (bl && i > msd) ? 8'h00 : GLYPH[d[i]];
    end
    for (int i = 0; i < 4; i++) r[8*i+7] = r[8*i+7] | dpv[i];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input int unsigned v, input bit hx, input bit bl, input logic [3:0] dpv,
                        input string tag);
    int guard;
    int lat;
    int exp_lat;
    bit ready_low;
    logic [31:0] exp;
    exp     = model(v, hx, bl, dpv);
    exp_lat = hx ? 1 : WIDTH + 1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    value    = WIDTH'(v);
    hex_mode = hx;
    blank_lz = bl;
    dp       = dpv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    value    = WIDTH'($urandom);
    hex_mode = 1'($urandom);
    blank_lz = 1'($urandom);
    dp       = 4'($urandom);
    lat = 0;
    ready_low = 1'b1;
    while (!updated && lat < 40) begin
      if (in_ready) ready_low = 1'b0;
      in_valid = (!hx && lat >= 2 && lat <= 4);
      tick();
      lat++;
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_ready_low"}, {31'h0, ready_low}, 32'h1);
    check({tag, "_digits"}, four_digits, exp);
    tick();
    check({tag, "_pulse_end"}, {31'h0, updated}, 32'h0);
  endtask

  initial begin
    int unsigned rv;
    bit seen_upd;
    rst      = 1'b1;
    in_valid = 1'b1;
    value    = 16'd1234;
    hex_mode = 1'b0;
    blank_lz = 1'b0;
    dp       = 4'h0;
    repeat (4) tick();
    check("rst_digits", four_digits, 32'h0000_0000);
    check("rst_updated", {31'h0, updated}, 32'h0);
    check("rst_ready", {31'h0, in_ready}, 32'h1);
    in_valid = 1'b0;
    rst      = 1'b0;
    seen_upd = 1'b0;
    repeat (20) begin
      tick();
      if (updated) seen_upd = 1'b1;
    end
    check("post_rst_no_conv", {31'h0, seen_upd}, 32'h0);
    check("post_rst_dark", four_digits, 32'h0000_0000);

    do_req(1234, 1'b0, 1'b0, 4'h0, "dec1234");
    check("dec1234_const", four_digits, 32'h065B_4F66);
    do_req(42, 1'b0, 1'b1, 4'b0010, "dec42");
    check("dec42_const", four_digits, 32'h0000_E65B);
    do_req(0, 1'b0, 1'b1, 4'h0, "dec0");
    check("dec0_const", four_digits, 32'h0000_003F);
    do_req(16'hBEEF, 1'b1, 1'b0, 4'h0, "hexBEEF");
    check("hexBEEF_const", four_digits, 32'h7C79_7971);
    do_req(10000, 1'b0, 1'b1, 4'h0, "dec10000");
    check("dec10000_const", four_digits, 32'h4040_4040);
    do_req(9999, 1'b0, 1'b1, 4'b1001, "dec9999");
    do_req(65535, 1'b0, 1'b0, 4'b0101, "dec65535");
    do_req(100, 1'b0, 1'b1, 4'b1111, "dec100");

    // Abort a decimal conversion with reset at T+5.
    value    = 16'd1234;
    hex_mode = 1'b0;
    blank_lz = 1'b0;
    dp       = 4'h0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_dark", four_digits, 32'h0000_0000);
    seen_upd = 1'b0;
    repeat (25) begin
      tick();
      if (updated) seen_upd = 1'b1;
    end
    check("abort_no_update", {31'h0, seen_upd}, 32'h0);
    check("abort_ready", {31'h0, in_ready}, 32'h1);
    do_req(7, 1'b0, 1'b0, 4'h0, "after_abort7");
    check("after_abort7_const", four_digits, 32'h3F3F_3F07);

    for (int k = 0; k < 30; k++) begin
      case ($urandom_range(0, 2))
        0:       rv = $urandom_range(0, 99);
        1:       rv = $urandom_range(0, 9999);
        default: rv = $urandom_range(0, 65535);
      endcase
      do_req(rv, 1'($urandom), 1'($urandom), 4'($urandom), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
